// File: rtl/aes256_ctr_arbiter.sv
// aes256_ctr_arbiter: shares one aes256_ctr_comb core between two AXI-Stream
// requesters, one whole message at a time (key, counter, text ... tlast).
//
// Handshake semantics (every stream here): a beat transfers on a rising Clk
// edge where tvalid and tready are both 1. A source holds tvalid and its payload
// stable until that beat transfers. The arbiter only routes the two signals
// combinationally and never creates a transfer on its own.
module aes256_ctr_arbiter #(
    parameter int AXIS_WIDTH = 64
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    // requester input streams
    input  logic [1:0]                S_axis_tvalid,
    output logic [1:0]                S_axis_tready,
    input  logic [2*AXIS_WIDTH-1:0]   S_axis_tdata,
    input  logic [2*AXIS_WIDTH/8-1:0] S_axis_tkeep,
    input  logic [1:0]                S_axis_tlast,
    input  logic [1:0]                S_axis_tuser,
    // core input stream
    output logic                      Core_s_tvalid,
    input  logic                      Core_s_tready,
    output logic [AXIS_WIDTH-1:0]     Core_s_tdata,
    output logic [AXIS_WIDTH/8-1:0]   Core_s_tkeep,
    output logic                      Core_s_tlast,
    output logic                      Core_s_tuser,
    // core output stream
    input  logic                      Core_m_tvalid,
    output logic                      Core_m_tready,
    input  logic [AXIS_WIDTH-1:0]     Core_m_tdata,
    input  logic [AXIS_WIDTH/8-1:0]   Core_m_tkeep,
    input  logic                      Core_m_tlast,
    // requester result streams
    output logic [1:0]                M_axis_tvalid,
    input  logic [1:0]                M_axis_tready,
    output logic [2*AXIS_WIDTH-1:0]   M_axis_tdata,
    output logic [2*AXIS_WIDTH/8-1:0] M_axis_tkeep,
    output logic [1:0]                M_axis_tlast,
    // observation of the arbitration state
    output logic [1:0]                Dbg_state,
    output logic                      Dbg_grant,
    output logic                      Dbg_last_grant
);

    localparam int KW = AXIS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic       grant;
    logic       last_grant;
    logic [1:0] grant_oh;
    logic       s_on;
    logic       m_on;
    logic       s_last_xfer;
    logic       m_last_xfer;

    // Input side is open only while forwarding; output side from grant until
    // the final result beat leaves.
    assign s_on     = (state == FWD);
    assign m_on     = (state == FWD) || (state == DRAIN);
    assign grant_oh = {grant, ~grant};

    assign s_last_xfer = Core_s_tvalid && Core_s_tready && Core_s_tlast;
    assign m_last_xfer = Core_m_tvalid && Core_m_tready && Core_m_tlast;

    // Requester -> core routing; everything is zero outside FWD.
    assign Core_s_tvalid = s_on && S_axis_tvalid[grant];
    assign Core_s_tdata  = !s_on ? '0 :
                           (grant ? S_axis_tdata[AXIS_WIDTH +: AXIS_WIDTH]
                                  : S_axis_tdata[0 +: AXIS_WIDTH]);
    assign Core_s_tkeep  = !s_on ? '0 :
                           (grant ? S_axis_tkeep[KW +: KW] : S_axis_tkeep[0 +: KW]);
    assign Core_s_tlast  = s_on && S_axis_tlast[grant];
    assign Core_s_tuser  = s_on && S_axis_tuser[grant];

    // Core -> requester routing back to the granted slice only.
    assign Core_m_tready = m_on && M_axis_tready[grant];

    for (genvar i = 0; i < 2; i++) begin : g_port
        logic s_sel;
        logic m_sel;
        assign s_sel = s_on && grant_oh[i];
        assign m_sel = m_on && grant_oh[i];

        assign S_axis_tready[i]                    = s_sel && Core_s_tready;
        assign M_axis_tvalid[i]                    = m_sel && Core_m_tvalid;
        assign M_axis_tlast[i]                     = m_sel && Core_m_tlast;
        assign M_axis_tdata[i*AXIS_WIDTH +: AXIS_WIDTH] = m_sel ? Core_m_tdata : '0;
        assign M_axis_tkeep[i*KW +: KW]            = m_sel ? Core_m_tkeep : '0;
    end

    assign Dbg_state      = state;
    assign Dbg_grant      = grant;
    assign Dbg_last_grant = last_grant;

    // Message-level round-robin FSM; grant is frozen from IDLE exit to DRAIN exit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|S_axis_tvalid) begin
                        state <= FWD;
                        if (&S_axis_tvalid) begin
                            grant <= ~last_grant;
                        end else begin
                            grant <= S_axis_tvalid[1];
                        end
                    end
                end
                FWD: begin
                    // a result tlast seen here is a core protocol error and is ignored
                    if (s_last_xfer) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_last_xfer) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_ctr_arbiter.sv
// Directed bench for aes256_ctr_arbiter: the bench plays both requesters and
// the core. Inputs change 1 time unit after a rising Clk edge; outputs are
// checked 1 time unit later, well away from either edge.
module tb_aes256_ctr_arbiter;

    localparam int AW = 64;
    localparam int KW = AW / 8;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic [1:0]      S_axis_tvalid;
    logic [1:0]      S_axis_tready;
    logic [2*AW-1:0] S_axis_tdata;
    logic [2*KW-1:0] S_axis_tkeep;
    logic [1:0]      S_axis_tlast;
    logic [1:0]      S_axis_tuser;
    logic            Core_s_tvalid;
    logic            Core_s_tready;
    logic [AW-1:0]   Core_s_tdata;
    logic [KW-1:0]   Core_s_tkeep;
    logic            Core_s_tlast;
    logic            Core_s_tuser;
    logic            Core_m_tvalid;
    logic            Core_m_tready;
    logic [AW-1:0]   Core_m_tdata;
    logic [KW-1:0]   Core_m_tkeep;
    logic            Core_m_tlast;
    logic [1:0]      M_axis_tvalid;
    logic [1:0]      M_axis_tready;
    logic [2*AW-1:0] M_axis_tdata;
    logic [2*KW-1:0] M_axis_tkeep;
    logic [1:0]      M_axis_tlast;
    logic [1:0]      Dbg_state;
    logic            Dbg_grant;
    logic            Dbg_last_grant;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FWD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    aes256_ctr_arbiter #(.AXIS_WIDTH(AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .S_axis_tvalid(S_axis_tvalid), .S_axis_tready(S_axis_tready),
        .S_axis_tdata(S_axis_tdata), .S_axis_tkeep(S_axis_tkeep),
        .S_axis_tlast(S_axis_tlast), .S_axis_tuser(S_axis_tuser),
        .Core_s_tvalid(Core_s_tvalid), .Core_s_tready(Core_s_tready),
        .Core_s_tdata(Core_s_tdata), .Core_s_tkeep(Core_s_tkeep),
        .Core_s_tlast(Core_s_tlast), .Core_s_tuser(Core_s_tuser),
        .Core_m_tvalid(Core_m_tvalid), .Core_m_tready(Core_m_tready),
        .Core_m_tdata(Core_m_tdata), .Core_m_tkeep(Core_m_tkeep),
        .Core_m_tlast(Core_m_tlast),
        .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(M_axis_tready),
        .M_axis_tdata(M_axis_tdata), .M_axis_tkeep(M_axis_tkeep),
        .M_axis_tlast(M_axis_tlast),
        .Dbg_state(Dbg_state), .Dbg_grant(Dbg_grant), .Dbg_last_grant(Dbg_last_grant)
    );

    // ---------------- clock / reset block ----------------
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        S_axis_tvalid = '0; S_axis_tdata = '0; S_axis_tkeep = '0;
        S_axis_tlast  = '0; S_axis_tuser = '0;
        Core_s_tready = 1'b1;
        Core_m_tvalid = 1'b0; Core_m_tdata = '0; Core_m_tkeep = '0; Core_m_tlast = 1'b0;
        M_axis_tready = 2'b11;
    endtask

    function automatic logic [AW-1:0] beat_data(input int r, input int b, input logic [7:0] tag);
        return {tag, 24'h0, 8'(r), 16'h0, 8'(b)};
    endfunction

    // One full message from requester r: 4 key + 2 counter + 2 text beats,
    // then 2 result beats from the core. The other requester is held valid
    // (waiting on its own first beat) when other_valid is set.
    task automatic drive_message(input int r, input bit other_valid,
                                 input logic [7:0] last_keep, input int bp_cycles,
                                 input logic [7:0] tag);
        int o;
        logic [1:0]    exp_rdy;
        logic [AW-1:0] d;
        logic [KW-1:0] k;
        o = 1 - r;
        exp_rdy = 2'b01 << r;
        S_axis_tvalid[r] = 1'b1;
        S_axis_tvalid[o] = other_valid;
        S_axis_tdata[r*AW +: AW] = beat_data(r, 0, tag);
        S_axis_tkeep[r*KW +: KW] = 8'hFF;
        S_axis_tlast[r] = 1'b0;
        S_axis_tuser[r] = tag[0];
        if (other_valid) S_axis_tdata[o*AW +: AW] = beat_data(o, 0, 8'hEE);
        #1;
        checks++; if (Dbg_state !== ST_IDLE) begin errors++; $display("FAIL arb_state_idle: got %0d expected %0d", Dbg_state, ST_IDLE); end
        checks++; if (S_axis_tready !== 2'b00) begin errors++; $display("FAIL arb_bubble_tready: got %b expected 00", S_axis_tready); end
        checks++; if (Core_s_tvalid !== 1'b0) begin errors++; $display("FAIL arb_bubble_core_valid: got %b expected 0", Core_s_tvalid); end
        tick();
        checks++; if (Dbg_grant !== 1'(r)) begin errors++; $display("FAIL grant: got %0d expected %0d", Dbg_grant, r); end
        checks++; if (Dbg_state !== ST_FWD) begin errors++; $display("FAIL state_fwd: got %0d expected %0d", Dbg_state, ST_FWD); end
        for (int b = 0; b < 8; b++) begin
            d = beat_data(r, b, tag);
            k = (b == 7) ? last_keep : 8'hFF;
            S_axis_tdata[r*AW +: AW] = d;
            S_axis_tkeep[r*KW +: KW] = k;
            S_axis_tlast[r] = (b == 7);
            #1;
            checks++; if (Core_s_tvalid !== 1'b1) begin errors++; $display("FAIL core_s_tvalid b%0d: got %b expected 1", b, Core_s_tvalid); end
            checks++; if (Core_s_tdata !== d) begin errors++; $display("FAIL core_s_tdata b%0d: got %h expected %h", b, Core_s_tdata, d); end
            checks++; if (Core_s_tkeep !== k) begin errors++; $display("FAIL core_s_tkeep b%0d: got %h expected %h", b, Core_s_tkeep, k); end
            checks++; if (Core_s_tlast !== (b == 7)) begin errors++; $display("FAIL core_s_tlast b%0d: got %b expected %b", b, Core_s_tlast, (b == 7)); end
            checks++; if (Core_s_tuser !== tag[0]) begin errors++; $display("FAIL core_s_tuser b%0d: got %b expected %b", b, Core_s_tuser, tag[0]); end
            checks++; if (S_axis_tready !== exp_rdy) begin errors++; $display("FAIL s_tready b%0d: got %b expected %b", b, S_axis_tready, exp_rdy); end
            checks++; if (M_axis_tvalid !== 2'b00) begin errors++; $display("FAIL m_tvalid_fwd b%0d: got %b expected 00", b, M_axis_tvalid); end
            tick();
        end
        S_axis_tvalid[r] = 1'b0;
        S_axis_tlast[r]  = 1'b0;
        checks++; if (Dbg_state !== ST_DRAIN) begin errors++; $display("FAIL state_drain: got %0d expected %0d", Dbg_state, ST_DRAIN); end
        // result beats
        Core_m_tvalid = 1'b1;
        Core_m_tdata  = {tag, 8'hA5, 40'h0, 8'h00};
        Core_m_tkeep  = 8'hFF;
        Core_m_tlast  = 1'b0;
        M_axis_tready[r] = 1'b0;
        for (int c = 0; c < bp_cycles; c++) begin
            #1;
            checks++; if (Core_m_tready !== 1'b0) begin errors++; $display("FAIL bp_core_m_tready c%0d: got %b expected 0", c, Core_m_tready); end
            checks++; if (Dbg_state !== ST_DRAIN) begin errors++; $display("FAIL bp_state c%0d: got %0d expected %0d", c, Dbg_state, ST_DRAIN); end
            checks++; if (S_axis_tready !== 2'b00) begin errors++; $display("FAIL bp_s_tready c%0d: got %b expected 00", c, S_axis_tready); end
            checks++; if (M_axis_tvalid !== exp_rdy) begin errors++; $display("FAIL bp_m_tvalid c%0d: got %b expected %b", c, M_axis_tvalid, exp_rdy); end
            tick();
        end
        M_axis_tready[r] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            d = {tag, 8'hA5, 40'h0, 8'(c)};
            k = (c == 1) ? last_keep : 8'hFF;
            Core_m_tdata = d;
            Core_m_tkeep = k;
            Core_m_tlast = (c == 1);
            #1;
            checks++; if (M_axis_tvalid !== exp_rdy) begin errors++; $display("FAIL m_tvalid c%0d: got %b expected %b", c, M_axis_tvalid, exp_rdy); end
            checks++; if (M_axis_tdata[r*AW +: AW] !== d) begin errors++; $display("FAIL m_tdata c%0d: got %h expected %h", c, M_axis_tdata[r*AW +: AW], d); end
            checks++; if (M_axis_tdata[o*AW +: AW] !== '0) begin errors++; $display("FAIL m_tdata_other c%0d: got %h expected 0", c, M_axis_tdata[o*AW +: AW]); end
            checks++; if (M_axis_tkeep[r*KW +: KW] !== k) begin errors++; $display("FAIL m_tkeep c%0d: got %h expected %h", c, M_axis_tkeep[r*KW +: KW], k); end
            checks++; if (M_axis_tlast !== ((c == 1) ? exp_rdy : 2'b00)) begin errors++; $display("FAIL m_tlast c%0d: got %b expected %b", c, M_axis_tlast, ((c == 1) ? exp_rdy : 2'b00)); end
            checks++; if (Core_m_tready !== 1'b1) begin errors++; $display("FAIL core_m_tready c%0d: got %b expected 1", c, Core_m_tready); end
            checks++; if (S_axis_tready !== 2'b00) begin errors++; $display("FAIL drain_s_tready c%0d: got %b expected 00", c, S_axis_tready); end
            tick();
        end
        Core_m_tvalid = 1'b0;
        Core_m_tlast  = 1'b0;
        Core_m_tdata  = '0;
        Core_m_tkeep  = '0;
        #1;
        checks++; if (Dbg_state !== ST_IDLE) begin errors++; $display("FAIL state_back_idle: got %0d expected %0d", Dbg_state, ST_IDLE); end
        checks++; if (Dbg_last_grant !== 1'(r)) begin errors++; $display("FAIL last_grant: got %b expected %0d", Dbg_last_grant, r); end
        checks++; if (Core_m_tready !== 1'b0) begin errors++; $display("FAIL idle_core_m_tready: got %b expected 0", Core_m_tready); end
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        Rst_n = 1'b0;
        clear_inputs();
        S_axis_tvalid = 2'b11;
        S_axis_tdata  = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        S_axis_tkeep  = 16'hFFFF;
        S_axis_tlast  = 2'b11;
        S_axis_tuser  = 2'b11;
        Core_m_tvalid = 1'b1;
        Core_m_tdata  = 64'hDEAD_BEEF_0000_0001;
        Core_m_tkeep  = 8'hFF;
        Core_m_tlast  = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (S_axis_tready !== 2'b00) begin errors++; $display("FAIL rst_s_tready: got %b expected 00", S_axis_tready); end
        checks++; if (Core_s_tvalid !== 1'b0) begin errors++; $display("FAIL rst_core_s_tvalid: got %b expected 0", Core_s_tvalid); end
        checks++; if ({Core_s_tdata, Core_s_tkeep, Core_s_tlast, Core_s_tuser} !== '0) begin errors++; $display("FAIL rst_core_s_payload: got %h expected 0", {Core_s_tdata, Core_s_tkeep}); end
        checks++; if (Core_m_tready !== 1'b0) begin errors++; $display("FAIL rst_core_m_tready: got %b expected 0", Core_m_tready); end
        checks++; if (M_axis_tvalid !== 2'b00) begin errors++; $display("FAIL rst_m_tvalid: got %b expected 00", M_axis_tvalid); end
        checks++; if ({M_axis_tdata, M_axis_tkeep, M_axis_tlast} !== '0) begin errors++; $display("FAIL rst_m_payload: got %h expected 0", M_axis_tdata); end
        checks++; if (Dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", Dbg_state); end
        checks++; if (Dbg_grant !== 1'b0) begin errors++; $display("FAIL rst_grant: got %b expected 0", Dbg_grant); end
        checks++; if (Dbg_last_grant !== 1'b1) begin errors++; $display("FAIL rst_last_grant: got %b expected 1", Dbg_last_grant); end
        clear_inputs();
        #2 Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive_message(0, 1'b0, 8'hFF, 0, 8'h10);
    endtask

    task automatic test_both_after_reset();
        clear_inputs();
        Rst_n = 1'b0;
        #2 Rst_n = 1'b1;
        tick();
        drive_message(0, 1'b1, 8'hFF, 0, 8'h21);
        drive_message(1, 1'b0, 8'hFF, 0, 8'h22);
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 6; m++) begin
            drive_message(m % 2, 1'b1, 8'hFF, 0, 8'(8'h30 + m));
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        drive_message(0, 1'b1, 8'hFF, 5, 8'h41);
        drive_message(1, 1'b0, 8'hFF, 0, 8'h42);
    endtask

    task automatic test_partial_keep();
        drive_message(0, 1'b0, 8'h0F, 0, 8'h51);
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        // last_grant is 0 here, so only reset can make a tie favour requester 0
        checks++; if (Dbg_last_grant !== 1'b0) begin errors++; $display("FAIL pre_reset_last_grant: got %b expected 0", Dbg_last_grant); end
        S_axis_tvalid = 2'b01;
        S_axis_tdata[0 +: AW] = beat_data(0, 0, 8'h60);
        S_axis_tkeep[0 +: KW] = 8'hFF;
        tick();
        tick();
        Core_m_tvalid = 1'b1;
        S_axis_tvalid = 2'b11;
        #1;
        checks++; if (S_axis_tready !== 2'b01) begin errors++; $display("FAIL mid_fwd_tready: got %b expected 01", S_axis_tready); end
        Rst_n = 1'b0;
        #1;
        checks++; if (S_axis_tready !== 2'b00) begin errors++; $display("FAIL async_s_tready: got %b expected 00", S_axis_tready); end
        checks++; if (Core_s_tvalid !== 1'b0) begin errors++; $display("FAIL async_core_s_tvalid: got %b expected 0", Core_s_tvalid); end
        checks++; if (M_axis_tvalid !== 2'b00) begin errors++; $display("FAIL async_m_tvalid: got %b expected 00", M_axis_tvalid); end
        checks++; if (Core_m_tready !== 1'b0) begin errors++; $display("FAIL async_core_m_tready: got %b expected 0", Core_m_tready); end
        checks++; if (Dbg_state !== ST_IDLE) begin errors++; $display("FAIL async_state: got %0d expected 0", Dbg_state); end
        checks++; if (Dbg_last_grant !== 1'b1) begin errors++; $display("FAIL async_last_grant: got %b expected 1", Dbg_last_grant); end
        #1 Rst_n = 1'b1;
        clear_inputs();
        tick();
        drive_message(0, 1'b1, 8'hFF, 0, 8'h61);
        drive_message(1, 1'b0, 8'hFF, 0, 8'h62);
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single();
        test_both_after_reset();
        test_back_to_back();
        test_backpressure();
        test_partial_keep();
        test_reset_mid();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes256_ctr_arbiter.md
Name:
aes256_ctr_arbiter

Overview:
- Shares one aes256_ctr_comb core between two AXI-Stream requesters at message granularity.
- A message is: key beats, then counter beats, then text beats ending with tlast.
- Round-robin grant is held from the first key beat until the core's final output beat (tlast) is accepted by the granted requester.
- Sits between two requester ports and the core's S_axis/M_axis.

Parameters:
- AXIS_WIDTH, 64: data width of every stream. Legal values are 32, 64, 128. Must equal the core's S/M_AXIS_WIDTH.

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- S_axis_tvalid  in  2  per-requester valid; bit i belongs to requester i
- S_axis_tready  out  2  per-requester ready
- S_axis_tdata  in  2*AXIS_WIDTH  requester i uses slice [i*AXIS_WIDTH +: AXIS_WIDTH]
- S_axis_tkeep  in  2*AXIS_WIDTH/8  per-requester keep
- S_axis_tlast  in  2  per-requester last
- S_axis_tuser  in  2  per-requester user (encrypt flag)
- Core_s_tvalid  out  1  to core S_axis_tvalid
- Core_s_tready  in  1  from core S_axis_tready
- Core_s_tdata  out  AXIS_WIDTH  to core
- Core_s_tkeep  out  AXIS_WIDTH/8  to core
- Core_s_tlast  out  1  to core
- Core_s_tuser  out  1  to core
- Core_m_tvalid  in  1  from core M_axis_tvalid
- Core_m_tready  out  1  to core M_axis_tready
- Core_m_tdata  in  AXIS_WIDTH  from core
- Core_m_tkeep  in  AXIS_WIDTH/8  from core
- Core_m_tlast  in  1  from core
- M_axis_tvalid  out  2  per-requester result valid
- M_axis_tready  in  2  per-requester result ready
- M_axis_tdata  out  2*AXIS_WIDTH  per-requester result data, sliced as S_axis_tdata
- M_axis_tkeep  out  2*AXIS_WIDTH/8  per-requester result keep
- M_axis_tlast  out  2  per-requester result last

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous, active-low (Rst_n).
- Registers: state (IDLE, FWD, DRAIN), grant (1 bit), last_grant (1 bit).
- Reset values:
  - state=IDLE, grant=0, last_grant=1, so requester 0 wins the first tie.
  - All tready and tvalid outputs are 0.
  - All tdata, tkeep, tlast and tuser outputs are 0.
- Non-granted and IDLE outputs: any output that is not driven by the routing rules below is forced to 0.
- IDLE:
  - All S_axis_tready=0, Core_s_tvalid=0, Core_m_tready=0.
  - If any S_axis_tvalid is set: grant is the only valid requester, or !last_grant if both are valid. Next state is FWD.
  - Arbitration costs exactly one bubble cycle; no beat is accepted in IDLE.
- FWD (combinational passthrough, zero latency):
  - Core_s_tvalid=S_axis_tvalid[grant]; S_axis_tready[grant]=Core_s_tready.
  - Core_s_tdata, tkeep, tlast, tuser come from the granted slices.
  - The non-granted S_axis_tready is 0.
  - A handshake with Core_s_tlast=1 moves to DRAIN.
- Output routing (in FWD and DRAIN):
  - M_axis_tvalid[grant]=Core_m_tvalid; Core_m_tready=M_axis_tready[grant].
  - The granted M slices carry Core_m_tdata, tkeep and tlast.
  - The non-granted M_axis_tvalid is 0.
  - Output beats interleave with input beats in FWD; the core emits per-block output before the next input block.
- DRAIN:
  - All S_axis_tready=0.
  - A Core_m handshake with Core_m_tlast=1 sets last_grant<=grant and returns to IDLE.
- Core_m_tlast handshakes in FWD do not end the message. The core cannot legally produce one before input tlast, so this is a protocol error with no effect.
- No preemption: grant never changes between IDLE exit and DRAIN exit.
  - A requester dropping tvalid mid-message stalls the core; grant is held.
  - The other requester waits indefinitely.
- Requester contract:
  - tlast=0 on all key and counter beats.
  - tlast=1 only on the final text beat.
  - Key beat count = 256/AXIS_WIDTH; counter beat count = 128/AXIS_WIDTH.
- Back-to-back contention: the grant sequence alternates 0,1,0,1.
- Reset mid-message: asynchronous return to reset values. The core's synchronous Rst must be driven from the same reset tree; the arbiter does not flush the core.
- Latency:
  - 1 cycle from first S_axis_tvalid in IDLE to the first possible accepted beat.
  - 1 cycle from output tlast accept to the next arbitration decision.

Test Plan:
- Single message, AXIS_WIDTH=64: requester 0 only, 4 key + 2 counter + 2 text beats, tlast on beat 8.
  - Core_s sees 8 beats in order, identical data, keep and user.
  - Core's 2 output beats appear on M slice 0 with tlast on the second.
  - M_axis_tvalid[1] stays 0 and state returns to IDLE.
- Both requesters valid in the first cycle after reset:
  - Requester 0 is granted; S_axis_tready[1]=0 until M_axis_tlast[0] is accepted.
  - One IDLE cycle follows, then requester 1 is granted.
- Continuous contention, 3 messages per requester: grant sequence is exactly 0,1,0,1,0,1, with no beat of one requester reaching the other's M slice.
- Backpressure: M_axis_tready[0]=0 for 5 cycles in DRAIN.
  - Core_m_tready=0 for those 5 cycles and state stays DRAIN.
  - Requester 1 (valid) sees no tready until the release.
- Partial last block: final text beat with tkeep=8'h0F and tlast=1.
  - Core_s_tkeep=8'h0F is passed through unchanged.
  - The matching output beat keep is forwarded to the granted M slice.
- Rst_n pulsed low mid-FWD, between clock edges:
  - All tready and tvalid outputs drop to 0 immediately, without waiting for Clk.
  - state=IDLE, last_grant=1, and the next arbitration favours requester 0 on a tie.
